// File: rtl/ddos_pkg.sv
// Shared definitions for the DDoS bucket-counter memory: controller states and default widths.
package ddos_pkg;

  typedef enum logic [1:0] {
    ST_SWEEP = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_BITS  = 14;
  localparam int DEF_INC_WIDTH  = 16;
  localparam int DEF_SATURATE   = 1;

endpackage

// File: rtl/ddos_sdp_ram.sv
// Simple dual-port block RAM: one write port and one registered, read-first read port.
module ddos_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 14
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_BITS)-1];

  // Same-address read returns the old word because both updates are non-blocking.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ddos_count_bram.sv
// Per-bucket counter memory with pipelined read-modify-write increments, lookups and sweep-clear.
module ddos_count_bram
  import ddos_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int INC_WIDTH  = DEF_INC_WIDTH,
  parameter int SATURATE   = DEF_SATURATE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_valid,
  input  logic [ADDR_BITS-1:0]  inc_addr,
  input  logic [INC_WIDTH-1:0]  inc_amount,
  output logic                  inc_ready,
  input  logic                  rd_valid,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic                  rd_ready,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clear_req,
  output logic                  clear_busy
);

  state_t                state;
  state_t                next_state;
  logic [ADDR_BITS-1:0]  sweep_addr;
  logic                  sweep_last;

  logic                  rd_accept;
  logic                  inc_accept;
  logic [ADDR_BITS-1:0]  ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_we;
  logic [ADDR_BITS-1:0]  ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [ADDR_BITS-1:0]  prev_addr;

  logic                  s1_valid;
  logic [ADDR_BITS-1:0]  s1_addr;
  logic [INC_WIDTH-1:0]  s1_amount;
  logic [DATA_WIDTH:0]   sum_wide;
  logic [DATA_WIDTH-1:0] s1_sum;

  logic                  fw_valid;
  logic [ADDR_BITS-1:0]  fw_addr;
  logic [DATA_WIDTH-1:0] fw_value;
  logic                  fw_hit;
  logic [DATA_WIDTH-1:0] base;

  logic [DATA_WIDTH-1:0] rd_hold;

  assign sweep_last = (sweep_addr == {ADDR_BITS{1'b1}});
  assign rd_accept  = rd_valid & rd_ready;
  assign inc_accept = inc_valid & inc_ready;
  // Lookups win the single RAM read port; increments are stalled through inc_ready.
  assign ram_raddr  = rd_accept ? rd_addr : inc_addr;

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_SWEEP;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a clear skips DRAIN when no increment is in or entering S1.
  always_comb begin
    next_state = state;
    case (state)
      ST_SWEEP: begin
        if (sweep_last) begin
          next_state = ST_RUN;
        end else begin
          next_state = ST_SWEEP;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          if (s1_valid || inc_accept) begin
            next_state = ST_DRAIN;
          end else begin
            next_state = ST_SWEEP;
          end
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (s1_valid) begin
          next_state = ST_DRAIN;
        end else begin
          next_state = ST_SWEEP;
        end
      end
      default: next_state = ST_SWEEP;
    endcase
  end

  // Port handshakes and busy flag decoded from the current state.
  always_comb begin
    rd_ready   = 1'b0;
    inc_ready  = 1'b0;
    clear_busy = 1'b1;
    case (state)
      ST_RUN: begin
        rd_ready   = 1'b1;
        inc_ready  = ~rd_valid;
        clear_busy = 1'b0;
      end
      ST_SWEEP, ST_DRAIN: begin
        rd_ready   = 1'b0;
        inc_ready  = 1'b0;
        clear_busy = 1'b1;
      end
      default: begin
        rd_ready   = 1'b0;
        inc_ready  = 1'b0;
        clear_busy = 1'b1;
      end
    endcase
  end

  // Sweep address advances only while sweeping and wraps back to zero after the last bucket.
  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_addr <= {ADDR_BITS{1'b0}};
    end else if (state == ST_SWEEP) begin
      sweep_addr <= sweep_addr + ADDR_BITS'(1);
    end else begin
      sweep_addr <= {ADDR_BITS{1'b0}};
    end
  end

  // Remember which address the RAM output belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_addr <= {ADDR_BITS{1'b0}};
    end else begin
      prev_addr <= ram_raddr;
    end
  end

  // The forwarding register always holds the newest S1 write, so a hit beats the stale RAM word.
  assign fw_hit = fw_valid && (fw_addr == prev_addr);
  assign base   = fw_hit ? fw_value : ram_rdata;

  assign sum_wide = {1'b0, base} + {{(DATA_WIDTH + 1 - INC_WIDTH){1'b0}}, s1_amount};

  // Accumulate with optional clamp at all-ones.
  always_comb begin
    if ((SATURATE != 0) && sum_wide[DATA_WIDTH]) begin
      s1_sum = {DATA_WIDTH{1'b1}};
    end else begin
      s1_sum = sum_wide[DATA_WIDTH-1:0];
    end
  end

  // RAM write port: zeros during the sweep, otherwise the S1 result.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_addr;
    ram_wdata = s1_sum;
    if (state == ST_SWEEP) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_addr;
      ram_wdata = {DATA_WIDTH{1'b0}};
    end else if (s1_valid) begin
      ram_we    = 1'b1;
      ram_waddr = s1_addr;
      ram_wdata = s1_sum;
    end else begin
      ram_we    = 1'b0;
      ram_waddr = s1_addr;
      ram_wdata = s1_sum;
    end
  end

  // S1 stage capture of an accepted increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_addr   <= {ADDR_BITS{1'b0}};
      s1_amount <= {INC_WIDTH{1'b0}};
    end else begin
      s1_valid <= inc_accept;
      if (inc_accept) begin
        s1_addr   <= inc_addr;
        s1_amount <= inc_amount;
      end else begin
        s1_addr   <= s1_addr;
        s1_amount <= s1_amount;
      end
    end
  end

  // Forwarding register; dropped while sweeping since every bucket returns to zero.
  always_ff @(posedge clk) begin
    if (reset || (state == ST_SWEEP)) begin
      fw_valid <= 1'b0;
      fw_addr  <= {ADDR_BITS{1'b0}};
      fw_value <= {DATA_WIDTH{1'b0}};
    end else if (s1_valid) begin
      fw_valid <= 1'b1;
      fw_addr  <= s1_addr;
      fw_value <= s1_sum;
    end else begin
      fw_valid <= fw_valid;
      fw_addr  <= fw_addr;
      fw_value <= fw_value;
    end
  end

  // Lookup response flag and the value held between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_valid <= 1'b0;
      rd_hold       <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_data_valid <= rd_accept;
      if (rd_data_valid) begin
        rd_hold <= base;
      end else begin
        rd_hold <= rd_hold;
      end
    end
  end

  assign rd_data = rd_data_valid ? base : rd_hold;

  ddos_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ddos_count_bram.sv
// Scoreboard bench: a saturating and a wrapping instance share stimulus; reads are checked against a bucket model.
module tb_ddos_count_bram;

  localparam int DW = 8;
  localparam int AB = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          inc_valid;
  logic [AB-1:0] inc_addr;
  logic [IW-1:0] inc_amount;
  logic          rd_valid;
  logic [AB-1:0] rd_addr;
  logic          clear_req;

  logic          inc_ready_s, rd_ready_s, rdv_s, busy_s;
  logic [DW-1:0] rdata_s;
  logic          inc_ready_w, rd_ready_w, rdv_w, busy_w;
  logic [DW-1:0] rdata_w;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] mdl_s [16];
  logic [DW-1:0] mdl_w [16];
  logic [DW-1:0] exp_s_q [$];
  logic [DW-1:0] exp_w_q [$];
  logic          rd_pend;
  int            cnt;

  always #5 clk = ~clk;

  ddos_count_bram #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .INC_WIDTH(IW), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset),
    .inc_valid(inc_valid), .inc_addr(inc_addr), .inc_amount(inc_amount), .inc_ready(inc_ready_s),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready_s),
    .rd_data_valid(rdv_s), .rd_data(rdata_s),
    .clear_req(clear_req), .clear_busy(busy_s)
  );

  ddos_count_bram #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .INC_WIDTH(IW), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset),
    .inc_valid(inc_valid), .inc_addr(inc_addr), .inc_amount(inc_amount), .inc_ready(inc_ready_w),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready_w),
    .rd_data_valid(rdv_w), .rd_data(rdata_w),
    .clear_req(clear_req), .clear_busy(busy_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record accepted requests into model/scoreboard, step, then check responses.
  task automatic cycle();
    logic [DW:0] s;
    logic        inc_acc;
    #1;
    rd_pend = ((!reset) && rd_valid && rd_ready_s) === 1'b1;
    inc_acc = ((!reset) && inc_valid && inc_ready_s) === 1'b1;
    if (rd_pend) begin
      exp_s_q.push_back(mdl_s[rd_addr]);
      exp_w_q.push_back(mdl_w[rd_addr]);
    end
    if (inc_acc) begin
      s = {1'b0, mdl_s[inc_addr]} + {1'b0, inc_amount};
      mdl_s[inc_addr] = s[DW] ? {DW{1'b1}} : s[DW-1:0];
      s = {1'b0, mdl_w[inc_addr]} + {1'b0, inc_amount};
      mdl_w[inc_addr] = s[DW-1:0];
    end
    @(posedge clk);
    #1;
    check_eq("rd_data_valid_sat", 32'(rdv_s), 32'(rd_pend));
    check_eq("rd_data_valid_wrap", 32'(rdv_w), 32'(rd_pend));
    if (rd_pend && exp_s_q.size() > 0) begin
      check_eq("rd_data_sat", 32'(rdata_s), 32'(exp_s_q.pop_front()));
      check_eq("rd_data_wrap", 32'(rdata_w), 32'(exp_w_q.pop_front()));
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      rd_valid = 1'b1;
      rd_addr  = AB'(a);
      cycle();
    end
    rd_valid = 1'b0;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; inc_valid = 1'b0; inc_addr = '0; inc_amount = '0;
    rd_valid = 1'b0; rd_addr = '0; clear_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mdl_s[i] = '0;
      mdl_w[i] = '0;
    end
    repeat (3) cycle();
    check_eq("reset_busy", 32'(busy_s), 32'd1);
    check_eq("reset_inc_ready", 32'(inc_ready_s), 32'd0);
    check_eq("reset_rd_ready", 32'(rd_ready_s), 32'd0);
    check_eq("reset_rd_data", 32'(rdata_s), 32'd0);

    // Interrupt the sweep at address 7, then measure a full restarted sweep.
    reset = 1'b0;
    repeat (7) cycle();
    check_eq("mid_sweep_busy", 32'(busy_s), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cnt = 0;
    while (busy_s === 1'b1 && cnt < 100) begin
      cnt++;
      cycle();
    end
    check_eq("sweep_len", 32'(cnt), 32'd16);
    check_eq("run_busy_wrap", 32'(busy_w), 32'd0);
    check_eq("run_rd_ready", 32'(rd_ready_s), 32'd1);
    check_eq("run_inc_ready", 32'(inc_ready_s), 32'd1);

    // All buckets read back zero after the sweep.
    rd_valid = 1'b1;
    #1;
    check_eq("inc_ready_blocked_by_rd", 32'(inc_ready_s), 32'd0);
    read_all();

    // Three back-to-back increments, then an immediate read.
    inc_valid = 1'b1; inc_addr = 4'd3; inc_amount = 8'd5;
    repeat (3) cycle();
    inc_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 4'd3;
    cycle();
    rd_valid = 1'b0;
    cycle();
    check_eq("hold_after_fwd_read", 32'(rdata_s), 32'd15);

    // Saturate versus wrap on 200 + 200.
    inc_valid = 1'b1; inc_addr = 4'd1; inc_amount = 8'd200;
    repeat (2) cycle();
    inc_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 4'd1;
    cycle();
    rd_valid = 1'b0;
    cycle();
    check_eq("hold_sat", 32'(rdata_s), 32'd255);
    check_eq("hold_wrap", 32'(rdata_w), 32'd144);

    // Read and increment in the same cycle: read wins, increment follows.
    rd_valid = 1'b1; rd_addr = 4'd5;
    inc_valid = 1'b1; inc_addr = 4'd5; inc_amount = 8'd7;
    #1;
    check_eq("collide_inc_ready", 32'(inc_ready_s), 32'd0);
    check_eq("collide_rd_ready", 32'(rd_ready_s), 32'd1);
    cycle();
    rd_valid = 1'b0;
    #1;
    check_eq("retry_inc_ready", 32'(inc_ready_s), 32'd1);
    cycle();
    inc_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 4'd5;
    cycle();
    rd_valid = 1'b0;
    cycle();

    // Clear with an increment sitting in S1; a second clear mid-sweep is ignored.
    inc_valid = 1'b1; inc_addr = 4'd9; inc_amount = 8'd4;
    cycle();
    inc_valid = 1'b0;
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    check_eq("clear_busy", 32'(busy_s), 32'd1);
    check_eq("clear_rd_ready", 32'(rd_ready_s), 32'd0);
    cnt = 0;
    while (busy_s === 1'b1 && cnt < 100) begin
      clear_req = (cnt == 6);
      cnt++;
      cycle();
    end
    clear_req = 1'b0;
    check_eq("drain_plus_sweep_len", 32'(cnt), 32'd17);
    for (int i = 0; i < 16; i++) begin
      mdl_s[i] = '0;
      mdl_w[i] = '0;
    end
    read_all();

    check_eq("scoreboard_empty", 32'(exp_s_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
